// File: rtl/core_pkg.sv
// Shared core definitions: memory-op encoding, access sizes and MEM-stage state encoding.
package core_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  // Field layout of the 5-bit mem_op bus: [4] valid, [3] store, [2] unsigned, [1:0] size.
  typedef struct packed {
    logic       valid;
    logic       store;
    logic       uns;
    logic [1:0] size;
  } mem_op_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [7:0] lane_sel(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      MEM_B:   base = 8'h01;
      MEM_H:   base = 8'h03;
      MEM_W:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return off[0];
      MEM_W:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts a load lane from a 64-bit doubleword and sign/zero-extends it.
module load_align
  import core_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = '0;
    case (size)
      MEM_B:   data = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   data = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   data = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: passes ALU results through, or runs one req/ack data-bus
// transaction per load/store while stalling the pipeline.
module mem_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      mem_op_i,
  input  logic [4:0]      reg_write_addr_i,
  input  logic            reg_write_enable_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_write_addr_o,
  output logic            reg_write_enable_o,
  output logic            stall_req_o,
  output logic            exc_misaligned_o,
  output logic            exc_access_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [7:0]      dbus_sel_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_ack_i,
  input  logic            dbus_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  ms_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [7:0]      sel_q, sel_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  mem_op_t         op;
  logic [2:0]      off;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wdata_rep;

  assign op  = mem_op_t'(mem_op_i);
  assign off = alu_result_i[2:0];

  load_align u_load_align (
    .rdata       (rdata_q),
    .offset      (off),
    .size        (op.size),
    .is_unsigned (op.uns),
    .data        (load_data)
  );

  always_comb begin
    case (op.size)
      MEM_B:   wdata_rep = {8{store_data_i[7:0]}};
      MEM_H:   wdata_rep = {4{store_data_i[15:0]}};
      MEM_W:   wdata_rep = {2{store_data_i[31:0]}};
      default: wdata_rep = store_data_i;
    endcase
  end

  // State and bus register bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, bus loads and write-back outputs.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    req_d              = req_q;
    we_d               = we_q;
    addr_d             = addr_q;
    sel_d              = sel_q;
    wdata_d            = wdata_q;
    rdata_d            = rdata_q;
    err_d              = err_q;
    result_o           = '0;
    reg_write_enable_o = 1'b0;
    stall_req_o        = 1'b0;
    exc_misaligned_o   = 1'b0;
    exc_access_o       = 1'b0;

    case (state_q)
      MS_IDLE: begin
        if (!op.valid) begin
          result_o           = alu_result_i;
          reg_write_enable_o = reg_write_enable_i;
        end else if (is_misaligned(op.size, off)) begin
          exc_misaligned_o = 1'b1;
        end else begin
          stall_req_o = 1'b1;
          req_d       = 1'b1;
          we_d        = op.store;
          addr_d      = {alu_result_i[XLEN-1:3], 3'b000};
          sel_d       = lane_sel(op.size, off);
          wdata_d     = wdata_rep;
          cnt_d       = '0;
          state_d     = MS_BUSY;
        end
      end
      MS_BUSY: begin
        stall_req_o = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (dbus_ack_i || dbus_err_i) begin
          req_d   = 1'b0;
          rdata_d = dbus_rdata_i;
          err_d   = dbus_err_i;
          state_d = MS_DONE;
        end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = MS_DONE;
        end
      end
      MS_DONE: begin
        state_d = MS_IDLE;
        if (err_q) begin
          exc_access_o = 1'b1;
        end else if (!op.store) begin
          result_o           = load_data;
          reg_write_enable_o = reg_write_enable_i;
        end
      end
      default: state_d = MS_IDLE;
    endcase

    // Quiet outputs while held in reset.
    if (!rst && state_q == MS_IDLE) begin
      result_o           = '0;
      reg_write_enable_o = 1'b0;
      stall_req_o        = 1'b0;
      exc_misaligned_o   = 1'b0;
      exc_access_o       = 1'b0;
    end
  end

  assign reg_write_addr_o = reg_write_addr_i;
  assign dbus_req_o       = req_q;
  assign dbus_we_o        = we_q;
  assign dbus_addr_o      = addr_q;
  assign dbus_sel_o       = sel_q;
  assign dbus_wdata_o     = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment, errors, timeout, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_result_i, store_data_i, dbus_rdata_i;
  logic [4:0]  mem_op_i, reg_write_addr_i;
  logic        reg_write_enable_i, dbus_ack_i, dbus_err_i;

  logic [63:0] result_o, dbus_addr_o, dbus_wdata_o;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_enable_o, stall_req_o, exc_misaligned_o, exc_access_o;
  logic        dbus_req_o, dbus_we_o;
  logic [7:0]  dbus_sel_o;

  logic [63:0] t_result, t_addr, t_wdata;
  logic [4:0]  t_wa;
  logic        t_we, t_stall, t_mis, t_acc, t_req, t_dwe;
  logic [7:0]  t_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk(clk), .rst(rst),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i),
    .reg_write_addr_i(reg_write_addr_i), .reg_write_enable_i(reg_write_enable_i),
    .result_o(result_o), .reg_write_addr_o(reg_write_addr_o),
    .reg_write_enable_o(reg_write_enable_o), .stall_req_o(stall_req_o),
    .exc_misaligned_o(exc_misaligned_o), .exc_access_o(exc_access_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i)
  );

  mem_stage #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i),
    .reg_write_addr_i(reg_write_addr_i), .reg_write_enable_i(reg_write_enable_i),
    .result_o(t_result), .reg_write_addr_o(t_wa),
    .reg_write_enable_o(t_we), .stall_req_o(t_stall),
    .exc_misaligned_o(t_mis), .exc_access_o(t_acc),
    .dbus_req_o(t_req), .dbus_we_o(t_dwe), .dbus_addr_o(t_addr),
    .dbus_sel_o(t_sel), .dbus_wdata_o(t_wdata),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One memory transaction on the default DUT; called at a negedge, returns at a negedge in IDLE.
  task automatic mem_txn(input string tag, input logic [4:0] op, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata, input int waits,
                         input logic err, input logic [63:0] exp_daddr, input logic [7:0] exp_sel,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_res,
                         input logic exp_we, input logic exp_acc);
    mem_op_i = op; alu_result_i = addr; store_data_i = sdata;
    reg_write_addr_i = 5'd7; reg_write_enable_i = 1'b1;
    #1;
    chk({tag, " issue stall"}, 64'(stall_req_o), 64'd1);
    chk({tag, " issue we"}, 64'(reg_write_enable_o), 64'd0);
    chk({tag, " issue req"}, 64'(dbus_req_o), 64'd0);
    @(negedge clk);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, " busy req"}, 64'(dbus_req_o), 64'd1);
      chk({tag, " busy stall"}, 64'(stall_req_o), 64'd1);
      chk({tag, " addr"}, dbus_addr_o, exp_daddr);
      chk({tag, " sel"}, 64'(dbus_sel_o), 64'(exp_sel));
      chk({tag, " wdata"}, dbus_wdata_o, exp_wdata);
      chk({tag, " dbus_we"}, 64'(dbus_we_o), 64'(op[3]));
      if (i == waits) begin
        dbus_ack_i = 1'b1; dbus_err_i = err; dbus_rdata_i = rdata;
      end
      @(negedge clk);
    end
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    #1;
    chk({tag, " done stall"}, 64'(stall_req_o), 64'd0);
    chk({tag, " done req"}, 64'(dbus_req_o), 64'd0);
    chk({tag, " done result"}, result_o, exp_res);
    chk({tag, " done we"}, 64'(reg_write_enable_o), 64'(exp_we));
    chk({tag, " done acc"}, 64'(exc_access_o), 64'(exp_acc));
    chk({tag, " done wa"}, 64'(reg_write_addr_o), 64'd7);
    mem_op_i = 5'd0;
    @(negedge clk);
    #1;
    chk({tag, " after stall"}, 64'(stall_req_o), 64'd0);
    chk({tag, " after acc"}, 64'(exc_access_o), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_op_i = 5'd0; alu_result_i = 64'h55; store_data_i = '0;
    reg_write_addr_i = 5'd3; reg_write_enable_i = 1'b1;
    dbus_rdata_i = '0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst result", result_o, 64'd0);
    chk("rst we", 64'(reg_write_enable_o), 64'd0);
    chk("rst stall", 64'(stall_req_o), 64'd0);
    chk("rst req", 64'(dbus_req_o), 64'd0);
    chk("rst addr", dbus_addr_o, 64'd0);
    chk("rst sel", 64'(dbus_sel_o), 64'd0);
    chk("rst wa", 64'(reg_write_addr_o), 64'd3);
    rst = 1'b1;
    @(negedge clk);

    // Pass-through
    alu_result_i = 64'h1234; reg_write_addr_i = 5'd5; reg_write_enable_i = 1'b1;
    #1;
    chk("pass result", result_o, 64'h1234);
    chk("pass wa", 64'(reg_write_addr_o), 64'd5);
    chk("pass we", 64'(reg_write_enable_o), 64'd1);
    chk("pass stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    chk("pass req", 64'(dbus_req_o), 64'd0);

    mem_txn("lb", 5'b10000, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 1'b0,
            64'h1000, 8'h08, 64'd0, 64'hFFFFFFFF_FFFFFF80, 1'b1, 1'b0);
    mem_txn("lhu", 5'b10101, 64'h4006, 64'd0, 64'hBEEF0000_00000000, 1, 1'b0,
            64'h4000, 8'hC0, 64'd0, 64'h00000000_0000BEEF, 1'b1, 1'b0);
    mem_txn("sw", 5'b11010, 64'h2004, 64'h12345678_DEADBEEF, 64'hFFFF, 3, 1'b0,
            64'h2000, 8'hF0, 64'hDEADBEEF_DEADBEEF, 64'd0, 1'b0, 1'b0);
    mem_txn("sb", 5'b11000, 64'h7005, 64'h000000A5, 64'd0, 0, 1'b0,
            64'h7000, 8'h20, 64'hA5A5A5A5_A5A5A5A5, 64'd0, 1'b0, 1'b0);
    mem_txn("lw ackerr", 5'b10010, 64'h5000, 64'd0, 64'h1111, 0, 1'b1,
            64'h5000, 8'h0F, 64'd0, 64'd0, 1'b0, 1'b1);

    // Misaligned doubleword load
    mem_op_i = 5'b10011; alu_result_i = 64'h3002; reg_write_enable_i = 1'b1;
    #1;
    chk("mis exc", 64'(exc_misaligned_o), 64'd1);
    chk("mis we", 64'(reg_write_enable_o), 64'd0);
    chk("mis stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    mem_op_i = 5'd0;
    #1;
    chk("mis req", 64'(dbus_req_o), 64'd0);
    chk("mis pulse end", 64'(exc_misaligned_o), 64'd0);
    @(negedge clk);

    // Timeout on the TIMEOUT=4 instance; default instance keeps waiting
    mem_op_i = 5'b10011; alu_result_i = 64'h6000; reg_write_enable_i = 1'b1;
    #1;
    chk("to issue stall", 64'(t_stall), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("to busy req", 64'(t_req), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("to done req", 64'(t_req), 64'd0);
    chk("to done acc", 64'(t_acc), 64'd1);
    chk("to done we", 64'(t_we), 64'd0);
    chk("to done result", t_result, 64'd0);
    chk("to done stall", 64'(t_stall), 64'd0);
    chk("dflt still req", 64'(dbus_req_o), 64'd1);
    chk("dflt still stall", 64'(stall_req_o), 64'd1);
    @(negedge clk);

    // Reset while the default instance is BUSY; a late ack must be ignored
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy req", 64'(dbus_req_o), 64'd0);
    chk("rstbusy stall", 64'(stall_req_o), 64'd0);
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'hDEAD;
    @(negedge clk);
    dbus_ack_i = 1'b0; rst = 1'b1; mem_op_i = 5'd0; alu_result_i = 64'h99;
    #1;
    chk("rstbusy late ack acc", 64'(exc_access_o), 64'd0);
    chk("rstbusy late ack req", 64'(dbus_req_o), 64'd0);
    chk("rstbusy idle result", result_o, 64'h99);
    @(negedge clk);
    chk("rstbusy stays idle", 64'(stall_req_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
